// File: rtl/pcm_pkg.sv
// Shared types and widths for the PCM SDRAM fetch path.
package pcm_pkg;

  localparam int SDRAM_AW = 25;
  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StWaitGrant,
    StRead,
    StDone
  } pcm_state_t;

endpackage

// File: rtl/pcm_fifo.sv
// Synchronous show-ahead FIFO: head always presents the oldest entry.
module pcm_fifo #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      level,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pcm_sdram_reader.sv
// Per-frame burst fetcher from the arbiter's PCM slot into a sample FIFO for the I2S side.
module pcm_sdram_reader
  import pcm_pkg::*;
#(
  parameter int unsigned         FIFO_DEPTH = 64,
  parameter int unsigned         BURST_LEN  = 32,
  parameter logic [SDRAM_AW-1:0] BASE_ADDR  = 25'h0000000,
  parameter logic [SDRAM_AW-1:0] END_ADDR   = 25'h1FFFFFF,
  localparam int unsigned        LW = $clog2(FIFO_DEPTH) + 1,
  localparam int unsigned        CW = $clog2(BURST_LEN) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_frame,
  input  logic                enable,
  input  logic                sdram_wait,
  input  logic                sdram_ac,
  input  logic [SAMPLE_W-1:0] sdram_data,
  output logic                sdram_rd,
  output logic [SDRAM_AW-1:0] sdram_addr,
  output logic                busy,
  output logic                done,
  input  logic                sample_rd,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                underrun,
  output logic [LW-1:0]       fifo_level
);

  pcm_state_t          state;
  logic [SDRAM_AW-1:0] cur_addr;
  logic [SDRAM_AW-1:0] next_addr;
  logic [CW-1:0]       cnt;
  logic [LW-1:0]       free;
  logic                room;
  logic                last_word;
  logic                push;
  logic                fifo_empty;
  logic                fifo_full;
  logic [SAMPLE_W-1:0] fifo_head;

  assign sdram_addr   = cur_addr;
  assign next_addr    = (cur_addr == END_ADDR) ? BASE_ADDR : cur_addr + 1'b1;
  assign free         = LW'(FIFO_DEPTH) - fifo_level;
  // The whole burst is reserved up front, so pushes can never overflow.
  assign room         = (free >= LW'(BURST_LEN));
  assign last_word    = (cnt == CW'(BURST_LEN - 1));
  assign push         = (state == StRead) && sdram_ac;
  assign sample       = fifo_empty ? '0 : fifo_head;
  assign sample_valid = !fifo_empty;

  pcm_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (sdram_data),
    .pop       (sample_rd),
    .head      (fifo_head),
    .level     (fifo_level),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      underrun <= 1'b0;
    end else if (sample_rd && fifo_empty) begin
      underrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= StIdle;
      cur_addr <= BASE_ADDR;
      cnt      <= '0;
      sdram_rd <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (new_frame) begin
            // A skipped frame still pulses done so the arbiter leaves the PCM slot.
            if (enable && room) begin
              state <= StWaitGrant;
              cnt   <= '0;
              busy  <= 1'b1;
            end else begin
              state <= StDone;
              done  <= 1'b1;
            end
          end
        end
        StWaitGrant: begin
          if (!sdram_wait) begin
            state    <= StRead;
            sdram_rd <= 1'b1;
          end
        end
        StRead: begin
          if (sdram_ac) begin
            cur_addr <= next_addr;
            cnt      <= cnt + 1'b1;
          end
          if (sdram_ac && last_word) begin
            state    <= StDone;
            sdram_rd <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else if (sdram_wait) begin
            state    <= StWaitGrant;
            sdram_rd <= 1'b0;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcm_sdram_reader.sv
// Bench for pcm_sdram_reader: vector table, corner sequences and random traffic vs a queue model.
module tb_pcm_sdram_reader;

  localparam int unsigned FIFO_DEPTH = 64;
  localparam int unsigned BURST_LEN  = 32;
  localparam logic [24:0] BASE_ADDR  = 25'd0;
  localparam logic [24:0] END_ADDR   = 25'd65;

  logic        clk;
  logic        reset;
  logic        new_frame;
  logic        enable;
  logic        sdram_wait;
  logic        sdram_ac;
  logic [15:0] sdram_data;
  logic        sdram_rd;
  logic [24:0] sdram_addr;
  logic        busy;
  logic        done;
  logic        sample_rd;
  logic [15:0] sample;
  logic        sample_valid;
  logic        underrun;
  logic [6:0]  fifo_level;

  pcm_sdram_reader #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .BURST_LEN  (BURST_LEN),
    .BASE_ADDR  (BASE_ADDR),
    .END_ADDR   (END_ADDR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .new_frame    (new_frame),
    .enable       (enable),
    .sdram_wait   (sdram_wait),
    .sdram_ac     (sdram_ac),
    .sdram_data   (sdram_data),
    .sdram_rd     (sdram_rd),
    .sdram_addr   (sdram_addr),
    .busy         (busy),
    .done         (done),
    .sample_rd    (sample_rd),
    .sample       (sample),
    .sample_valid (sample_valid),
    .underrun     (underrun),
    .fifo_level   (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef enum {MIdle, MBurst, MDone} mstate_t;

  int          checks;
  int          failures;
  logic [15:0] q[$];
  mstate_t     m_state;
  int          m_acks;
  logic [24:0] m_addr;
  logic        m_underrun;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the model advances and every observable output is compared.
  task automatic step(input logic r, input logic nf, input logic en, input logic w,
                      input logic ac, input logic pop);
    bit push;
    int lvl;
    reset      = r;
    new_frame  = nf;
    enable     = en;
    sdram_wait = w;
    sdram_ac   = ac;
    sdram_data = m_addr[15:0];
    sample_rd  = pop;
    push = ac && sdram_rd && !r;
    if (r) begin
      q.delete();
      m_state    = MIdle;
      m_addr     = BASE_ADDR;
      m_underrun = 1'b0;
      m_acks     = 0;
    end else begin
      lvl = q.size();
      if (pop) begin
        if (q.size() == 0) m_underrun = 1'b1;
        else void'(q.pop_front());
      end
      if (push) begin
        q.push_back(m_addr[15:0]);
        m_addr = (m_addr == END_ADDR) ? BASE_ADDR : m_addr + 25'd1;
      end
      case (m_state)
        MIdle: begin
          if (nf) begin
            if (en && (int'(FIFO_DEPTH) - lvl) >= int'(BURST_LEN)) begin
              m_state = MBurst;
              m_acks  = 0;
            end else begin
              m_state = MDone;
            end
          end
        end
        MBurst: begin
          if (push) begin
            m_acks++;
            if (m_acks == int'(BURST_LEN)) m_state = MDone;
          end
        end
        default: m_state = MIdle;
      endcase
    end
    @(posedge clk);
    #1;
    chk("level", 32'(fifo_level), 32'(q.size()));
    chk("sample_valid", 32'(sample_valid), 32'(q.size() != 0));
    chk("sample", 32'(sample), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    chk("underrun", 32'(underrun), 32'(m_underrun));
    chk("busy", 32'(busy), 32'(m_state == MBurst));
    chk("done", 32'(done), 32'(m_state == MDone));
    chk("addr", 32'(sdram_addr), 32'(m_addr));
    if (m_state != MBurst) chk("rd_outside_burst", 32'(sdram_rd), 32'd0);
  endtask

  // Arbiter that acknowledges every request while granted.
  task automatic arb_step(input logic nf, input logic en, input logic w, input logic pop);
    step(1'b0, nf, en, w, sdram_rd && !w, pop);
  endtask

  task automatic run_frame(input logic en, output int first_rd, output int done_at,
                           output int acks);
    first_rd = -1;
    done_at  = -1;
    acks     = 0;
    arb_step(1'b1, en, 1'b0, 1'b0);
    for (int c = 1; c < 200; c++) begin
      if (sdram_rd && first_rd < 0) first_rd = c;
      if (done) begin
        done_at = c;
        break;
      end
      if (sdram_rd) acks++;
      arb_step(1'b0, en, 1'b0, 1'b0);
    end
  endtask

  typedef struct {
    logic        en;
    int          pops;
    logic [24:0] exp_start;
    logic        exp_burst;
    int          exp_level;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int first_rd, done_at, acks, guard;
    int frame_cd;
    logic w, nf, en, pop, ac;

    checks   = 0;
    failures = 0;
    m_addr   = BASE_ADDR;
    m_state  = MIdle;
    m_acks   = 0;
    m_underrun = 1'b0;
    reset = 1'b1; new_frame = 1'b0; enable = 1'b0; sdram_wait = 1'b0;
    sdram_ac = 1'b0; sdram_data = '0; sample_rd = 1'b0;

    vecs[0] = '{en: 1'b0, pops: 0,  exp_start: 25'd0,  exp_burst: 1'b0, exp_level: 0};
    vecs[1] = '{en: 1'b1, pops: 0,  exp_start: 25'd0,  exp_burst: 1'b1, exp_level: 32};
    vecs[2] = '{en: 1'b1, pops: 0,  exp_start: 25'd32, exp_burst: 1'b1, exp_level: 64};
    vecs[3] = '{en: 1'b1, pops: 0,  exp_start: 25'd64, exp_burst: 1'b0, exp_level: 64};
    vecs[4] = '{en: 1'b1, pops: 24, exp_start: 25'd64, exp_burst: 1'b0, exp_level: 40};
    vecs[5] = '{en: 1'b1, pops: 8,  exp_start: 25'd64, exp_burst: 1'b1, exp_level: 64};
    vecs[6] = '{en: 1'b0, pops: 64, exp_start: 25'd30, exp_burst: 1'b0, exp_level: 0};

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_addr", 32'(sdram_addr), 32'(BASE_ADDR));
    chk("rst_rd", 32'(sdram_rd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);

    // Frame vectors; vec 5 starts at END_ADDR-1 and exercises the address wrap.
    for (int i = 0; i < 7; i++) begin
      for (int p = 0; p < vecs[i].pops; p++) arb_step(1'b0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("vec%0d_start", i), 32'(sdram_addr), 32'(vecs[i].exp_start));
      run_frame(vecs[i].en, first_rd, done_at, acks);
      chk($sformatf("vec%0d_burst", i), 32'(first_rd >= 0), 32'(vecs[i].exp_burst));
      if (vecs[i].exp_burst) begin
        chk($sformatf("vec%0d_latency", i), 32'(first_rd), 32'd2);
        chk($sformatf("vec%0d_acks", i), 32'(acks), 32'(BURST_LEN));
        chk($sformatf("vec%0d_done_at", i), 32'(done_at), 32'd34);
      end else begin
        chk($sformatf("vec%0d_done_at", i), 32'(done_at), 32'd1);
      end
      chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vecs[i].exp_level));
      arb_step(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Grant withdrawn for 5 cycles after 10 acks.
    acks = 0;
    arb_step(1'b1, 1'b1, 1'b0, 1'b0);
    for (guard = 0; guard < 50 && acks < 10; guard++) begin
      if (sdram_rd) acks++;
      arb_step(1'b0, 1'b1, 1'b0, 1'b0);
    end
    for (int k = 0; k < 5; k++) begin
      arb_step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("wait_rd_low", 32'(sdram_rd), 32'd0);
      chk("wait_busy", 32'(busy), 32'd1);
    end
    first_rd = -1;
    for (guard = 0; guard < 100 && !done; guard++) begin
      if (sdram_rd && first_rd < 0) begin
        first_rd = guard;
        chk("resume_addr", 32'(sdram_addr), 32'd40);
      end
      if (sdram_rd) acks++;
      arb_step(1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("wait_done", 32'(done), 32'd1);
    chk("wait_total_acks", 32'(acks), 32'(BURST_LEN));
    chk("wait_level", 32'(fifo_level), 32'd32);

    // Drain, then pop while empty.
    for (int p = 0; p < 32; p++) arb_step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("pre_underrun", 32'(underrun), 32'd0);
    arb_step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("underrun_set", 32'(underrun), 32'd1);
    chk("empty_sample", 32'(sample), 32'd0);
    for (int k = 0; k < 3; k++) arb_step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("underrun_sticky", 32'(underrun), 32'd1);

    // Push and pop together at level 63.
    run_frame(1'b1, first_rd, done_at, acks);
    arb_step(1'b0, 1'b1, 1'b0, 1'b0);
    acks = 0;
    arb_step(1'b1, 1'b1, 1'b0, 1'b0);
    for (guard = 0; guard < 100 && !done; guard++) begin
      if (sdram_rd && acks == 31) begin
        chk("lvl63_before", 32'(fifo_level), 32'd63);
        arb_step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("lvl63_after", 32'(fifo_level), 32'd63);
        acks++;
      end else begin
        if (sdram_rd) acks++;
        arb_step(1'b0, 1'b1, 1'b0, 1'b0);
      end
    end
    chk("lvl63_done", 32'(done), 32'd1);

    // Reset on the 15th ack of a burst.
    for (int p = 0; p < 31; p++) arb_step(1'b0, 1'b0, 1'b0, 1'b1);
    acks = 0;
    arb_step(1'b1, 1'b1, 1'b0, 1'b0);
    for (guard = 0; guard < 100 && acks < 14; guard++) begin
      if (sdram_rd) acks++;
      arb_step(1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("rst_mid_rd_before", 32'(sdram_rd), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rst_mid_rd", 32'(sdram_rd), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_level", 32'(fifo_level), 32'd0);
    chk("rst_mid_addr", 32'(sdram_addr), 32'(BASE_ADDR));
    chk("rst_mid_done", 32'(done), 32'd0);
    for (int k = 0; k < 3; k++) begin
      arb_step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("rst_mid_no_done", 32'(done), 32'd0);
    end

    // Random traffic against the queue model.
    w = 1'b0;
    frame_cd = 5;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(9) == 0) w = ~w;
      nf = 1'b0;
      if (frame_cd == 0) begin
        nf = 1'b1;
        frame_cd = $urandom_range(80, 15);
      end else begin
        frame_cd--;
      end
      en  = ($urandom_range(99) < 85);
      pop = ($urandom_range(99) < 35);
      if (sdram_rd) ac = !w && ($urandom_range(99) < 70);
      else          ac = ($urandom_range(9) == 0);
      step(1'b0, nf, en, w, ac, pop);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
